// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter and sequencer for a fixed-latency memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is data-port priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic              owner_d;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] resp_data;
  logic              pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_d;

  // On contention the port that was not served last wins.
  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) pick_d = !last_grant_d;
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  // The memory-side outputs double as the latched copy of the winning request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      count     <= '0;
      resp_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_d <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d   <= pick_d;
            mem_req   <= 1'b1;
            mem_we    <= pick_d ? d_we    : i_we;
            mem_addr  <= pick_d ? d_addr  : i_addr;
            mem_wdata <= pick_d ? d_wdata : i_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          count   <= CNT_W'(MEM_LATENCY - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (count == '0) begin
            resp_data <= mem_rdata;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= RESP;
          end else begin
            count <= count - 1'b1;
          end
        end
        RESP: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d <= owner_d;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign i_gnt   = busy && !owner_d;
  assign d_gnt   = busy && owner_d;
  assign i_done  = (state == RESP) && !owner_d;
  assign d_done  = (state == RESP) && owner_d;
  assign i_rdata = i_done ? resp_data : '0;
  assign d_rdata = d_done ? resp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default-latency instance plus a MEM_LATENCY=1 instance.
// Contention expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req, i_we, d_req, d_we;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_done, d_gnt, d_done, mem_req, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  logic        l1_i_req, l1_i_we, l1_d_req, l1_d_we;
  logic [31:0] l1_i_addr, l1_i_wdata, l1_d_addr, l1_d_wdata, l1_mem_rdata;
  logic        l1_i_gnt, l1_i_done, l1_d_gnt, l1_d_done, l1_mem_req, l1_mem_we, l1_busy;
  logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;

  int pass_cnt = 0;
  int check_cnt = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .i_req(l1_i_req), .i_we(l1_i_we), .i_addr(l1_i_addr), .i_wdata(l1_i_wdata),
    .i_gnt(l1_i_gnt), .i_done(l1_i_done), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_gnt(l1_d_gnt), .d_done(l1_d_done), .d_rdata(l1_d_rdata),
    .mem_req(l1_mem_req), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = 32'hBAD0_BAD0;
    l1_i_req = 0; l1_i_we = 0; l1_i_addr = '0; l1_i_wdata = '0;
    l1_d_req = 0; l1_d_we = 0; l1_d_addr = '0; l1_d_wdata = '0;
    l1_mem_rdata = 32'hFFFF_0000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #2;
    check_cnt++;
    if ({busy, mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0)
      $display("FAIL reset_mem: got busy=%b req=%b we=%b addr=%h wdata=%h expected all 0", busy, mem_req, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    check_cnt++;
    if ({i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata} !== 68'd0)
      $display("FAIL reset_ports: got i=%b/%b/%h d=%b/%b/%h expected all 0", i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    d_req = 1; d_we = 0; d_addr = 32'h0000_1004; mem_rdata = 32'hBAD0_BAD0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check_cnt++;
      if (mem_req !== (k == 1)) $display("FAIL read_mem_req c%0d: got %b expected %b", k, mem_req, (k == 1));
      else pass_cnt++;
      check_cnt++;
      if (busy !== (k >= 1 && k <= 6)) $display("FAIL read_busy c%0d: got %b expected %b", k, busy, (k <= 6));
      else pass_cnt++;
      check_cnt++;
      if (d_done !== (k == 6)) $display("FAIL read_d_done c%0d: got %b expected %b", k, d_done, (k == 6));
      else pass_cnt++;
      check_cnt++;
      if (d_rdata !== ((k == 6) ? 32'hDEAD_BEEF : 32'h0)) $display("FAIL read_d_rdata c%0d: got %h expected %h", k, d_rdata, ((k == 6) ? 32'hDEAD_BEEF : 32'h0));
      else pass_cnt++;
      check_cnt++;
      if ({i_gnt, i_done, i_rdata} !== 34'd0) $display("FAIL read_i_idle c%0d: got %b/%b/%h expected 0", k, i_gnt, i_done, i_rdata);
      else pass_cnt++;
      if (k <= 5) begin
        check_cnt++;
        if (mem_addr !== 32'h0000_1004) $display("FAIL read_mem_addr c%0d: got %h expected 00001004", k, mem_addr);
        else pass_cnt++;
      end
      mem_rdata = (k == 5) ? 32'hDEAD_BEEF : 32'hBAD0_BAD0;
      if (k == 6) d_req = 0;
    end
  endtask

  task automatic test_single_write();
    i_req = 1; i_we = 1; i_addr = 32'h40; i_wdata = 32'h1122_3344;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check_cnt++;
      if (mem_we !== (k == 1)) $display("FAIL write_mem_we c%0d: got %b expected %b", k, mem_we, (k == 1));
      else pass_cnt++;
      check_cnt++;
      if (i_done !== (k == 6)) $display("FAIL write_i_done c%0d: got %b expected %b", k, i_done, (k == 6));
      else pass_cnt++;
      check_cnt++;
      if (i_gnt !== (k <= 6)) $display("FAIL write_i_gnt c%0d: got %b expected %b", k, i_gnt, (k <= 6));
      else pass_cnt++;
      check_cnt++;
      if ({d_gnt, d_done, d_rdata} !== 34'd0) $display("FAIL write_d_idle c%0d: got %b/%b/%h expected 0", k, d_gnt, d_done, d_rdata);
      else pass_cnt++;
      if (k <= 5) begin
        check_cnt++;
        if ({mem_addr, mem_wdata} !== {32'h40, 32'h1122_3344})
          $display("FAIL write_mem_bus c%0d: got %h/%h expected 00000040/11223344", k, mem_addr, mem_wdata);
        else pass_cnt++;
      end
      if (k == 6) begin i_req = 0; i_we = 0; end
    end
  endtask

  task automatic test_contention();
    int i_done_at = -1;
    int d_done_at = -1;
    logic [31:0] i_got = '0;
    logic [31:0] d_got = '0;
    logic [31:0] first_addr = '0;
    logic [31:0] second_addr = '0;
    logic        second_issue = 1'b0;
    logic        idle_gap_req = 1'b1;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    i_req = 1; i_we = 0; i_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    mem_rdata = 32'hC0DE_0000;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 1) first_addr = mem_addr;
      if (k == 7) idle_gap_req = mem_req;
      if (k == 8) begin second_addr = mem_addr; second_issue = mem_req; end
      if (i_done && i_done_at < 0) begin i_done_at = k; i_got = i_rdata; i_req = 0; end
      if (d_done && d_done_at < 0) begin d_done_at = k; d_got = d_rdata; d_req = 0; end
      mem_rdata = 32'hC0DE_0000 + 32'(k);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check_cnt++;
    if (i_done_at != 6 || d_done_at != 13) $display("FAIL cont_order: got i_done c%0d d_done c%0d expected i c6 d c13", i_done_at, d_done_at);
    else pass_cnt++;
    check_cnt++;
    if ({i_got, d_got} !== {32'hC0DE_0005, 32'hC0DE_000C}) $display("FAIL cont_rdata: got i=%h d=%h expected i=c0de0005 d=c0de000c", i_got, d_got);
    else pass_cnt++;
    check_cnt++;
    if ({first_addr, second_addr} !== {32'h10, 32'h20}) $display("FAIL cont_addr: got %h then %h expected 10 then 20", first_addr, second_addr);
    else pass_cnt++;
`else
    check_cnt++;
    if (d_done_at != 6 || i_done_at != 13) $display("FAIL cont_order: got d_done c%0d i_done c%0d expected d c6 i c13", d_done_at, i_done_at);
    else pass_cnt++;
    check_cnt++;
    if ({d_got, i_got} !== {32'hC0DE_0005, 32'hC0DE_000C}) $display("FAIL cont_rdata: got d=%h i=%h expected d=c0de0005 i=c0de000c", d_got, i_got);
    else pass_cnt++;
    check_cnt++;
    if ({first_addr, second_addr} !== {32'h20, 32'h10}) $display("FAIL cont_addr: got %h then %h expected 20 then 10", first_addr, second_addr);
    else pass_cnt++;
`endif
    check_cnt++;
    if ({idle_gap_req, second_issue} !== 2'b01) $display("FAIL cont_back_to_back: got req c7=%b c8=%b expected 0 1", idle_gap_req, second_issue);
    else pass_cnt++;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_req_change();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hAAAA_5555;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k <= 5) begin
        check_cnt++;
        if ({mem_addr, mem_wdata} !== {32'h100, 32'hAAAA_5555})
          $display("FAIL change_mem_bus c%0d: got %h/%h expected 00000100/aaaa5555", k, mem_addr, mem_wdata);
        else pass_cnt++;
      end
      check_cnt++;
      if (d_done !== (k == 6)) $display("FAIL change_d_done c%0d: got %b expected %b", k, d_done, (k == 6));
      else pass_cnt++;
      if (k == 2) begin d_addr = 32'h200; d_wdata = 32'h0; d_we = 0; end
      if (k == 3) d_req = 0;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    d_req = 0;
    #1;
    check_cnt++;
    if ({busy, mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0)
      $display("FAIL midreset_mem: got busy=%b req=%b we=%b addr=%h wdata=%h expected all 0", busy, mem_req, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    check_cnt++;
    if ({d_gnt, d_done, i_gnt} !== 3'd0) $display("FAIL midreset_gnt: got d_gnt=%b d_done=%b i_gnt=%b expected 0", d_gnt, d_done, i_gnt);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) reset = 1'b1;
      if (d_done || i_done) done_seen++;
    end
    check_cnt++;
    if (done_seen != 0) $display("FAIL midreset_no_done: got %0d done pulses expected 0", done_seen);
    else pass_cnt++;
    d_req = 1; d_addr = 32'h304;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k >= 5) begin
        check_cnt++;
        if ({d_done, d_rdata} !== ((k == 6) ? {1'b1, 32'h5A5A_5A5A} : 33'd0))
          $display("FAIL midreset_next c%0d: got done=%b rdata=%h expected done=%b", k, d_done, d_rdata, (k == 6));
        else pass_cnt++;
      end
      mem_rdata = (k == 5) ? 32'h5A5A_5A5A : 32'hBAD0_BAD0;
      if (k == 6) d_req = 0;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_latency_one();
    l1_d_req = 1; l1_d_we = 0; l1_d_addr = 32'h8;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check_cnt++;
      if (l1_mem_req !== (k == 1)) $display("FAIL lat1_mem_req c%0d: got %b expected %b", k, l1_mem_req, (k == 1));
      else pass_cnt++;
      check_cnt++;
      if ({l1_d_done, l1_d_rdata} !== ((k == 3) ? {1'b1, 32'h600D_F00D} : 33'd0))
        $display("FAIL lat1_done c%0d: got done=%b rdata=%h expected done=%b", k, l1_d_done, l1_d_rdata, (k == 3));
      else pass_cnt++;
      l1_mem_rdata = (k == 2) ? 32'h600D_F00D : 32'hFFFF_0000;
      if (k == 3) l1_d_req = 0;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_req_change();
    test_reset_mid();
    test_latency_one();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
